// File: rtl/mini_cpu_core_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mini_cpu_core_if : instruction handshake and result/flag bus        |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
interface mini_cpu_core_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W+3:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] result;
  logic              overflow;
  logic              done;
  logic              illegal;

  modport master (
    output in_data, in_valid,
    input  in_ready, result, overflow, done, illegal
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, result, overflow, done, illegal
  );
endinterface
`default_nettype wire

// File: rtl/mini_cpu_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mini_cpu_core : accumulator CPU with register file, shift-add MUL   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module mini_cpu_core #(
  parameter int DATA_W     = 8,
  parameter int REG_N      = 4,
  parameter int OVF_STICKY = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  mini_cpu_core_if.slave  bus
);
  localparam int IDX_W = $clog2(REG_N);
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_STR  = 4'hA;
  localparam logic [3:0] OP_ADDR = 4'hB;
  localparam logic [3:0] OP_CLRF = 4'hC;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0]   acc, acc_next;
  logic                ovf, ovf_next;
  logic                done, done_next;
  logic                illegal, illegal_next;
  logic [DATA_W-1:0]   regs [REG_N];
  logic                reg_we;
  logic [2*DATA_W-1:0] mcand, mcand_next;
  logic [2*DATA_W-1:0] prod, prod_next, prod_step;
  logic [DATA_W-1:0]   mplier, mplier_next;
  logic [CNT_W-1:0]    count, count_next;
  logic                ovf_wr, ovf_val;

  logic [3:0]        op;
  logic [DATA_W-1:0] opnd;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W:0]   add_sum, addr_sum;

  assign op       = bus.in_data[DATA_W+3:DATA_W];
  assign opnd     = bus.in_data[DATA_W-1:0];
  assign idx      = opnd[IDX_W-1:0];
  assign add_sum  = {1'b0, acc} + {1'b0, opnd};
  assign addr_sum = {1'b0, acc} + {1'b0, regs[idx]};
  assign prod_step = prod + (mplier[0] ? mcand : '0);

  assign bus.in_ready = (state == ST_IDLE);
  assign bus.result   = acc;
  assign bus.overflow = ovf;
  assign bus.done     = done;
  assign bus.illegal  = illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    acc_next     = acc;
    ovf_next     = ovf;
    done_next    = 1'b0;
    illegal_next = 1'b0;
    reg_we       = 1'b0;
    mcand_next   = mcand;
    mplier_next  = mplier;
    prod_next    = prod;
    count_next   = count;
    ovf_wr       = 1'b0;
    ovf_val      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          done_next = 1'b1;
          case (op)
            OP_NOP:  ;
            OP_LOAD: acc_next = opnd;
            OP_ADD:  begin acc_next = add_sum[DATA_W-1:0]; ovf_wr = 1'b1; ovf_val = add_sum[DATA_W]; end
            OP_SUB:  begin acc_next = acc - opnd; ovf_wr = 1'b1; ovf_val = (opnd > acc); end
            OP_MUL: begin
              // completion is reported when the shift-add sequence finishes
              done_next   = 1'b0;
              state_next  = ST_MUL;
              mcand_next  = {{DATA_W{1'b0}}, acc};
              mplier_next = opnd;
              prod_next   = '0;
              count_next  = CNT_W'(DATA_W);
            end
            OP_AND:  acc_next = acc & opnd;
            OP_OR:   acc_next = acc | opnd;
            OP_XOR:  acc_next = acc ^ opnd;
            OP_SHL:  begin acc_next = {acc[DATA_W-2:0], 1'b0}; ovf_wr = 1'b1; ovf_val = acc[DATA_W-1]; end
            OP_SHR:  acc_next = {1'b0, acc[DATA_W-1:1]};
            OP_STR:  reg_we = 1'b1;
            OP_ADDR: begin acc_next = addr_sum[DATA_W-1:0]; ovf_wr = 1'b1; ovf_val = addr_sum[DATA_W]; end
            OP_CLRF: ovf_next = 1'b0;
            default: illegal_next = 1'b1;
          endcase
        end
      end
      ST_MUL: begin
        prod_next   = prod_step;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        count_next  = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          acc_next   = prod_step[DATA_W-1:0];
          ovf_wr     = 1'b1;
          ovf_val    = |prod_step[2*DATA_W-1:DATA_W];
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (ovf_wr) ovf_next = (OVF_STICKY != 0) ? (ovf | ovf_val) : ovf_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      count   <= '0;
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else begin
      acc     <= acc_next;
      ovf     <= ovf_next;
      done    <= done_next;
      illegal <= illegal_next;
      mcand   <= mcand_next;
      mplier  <= mplier_next;
      prod    <= prod_next;
      count   <= count_next;
      if (reg_we) regs[idx] <= acc;
    end
  end
endmodule
`default_nettype wire
